// File: rtl/design_48_sched_if.sv
// Requester and datapath bus of the design_48 round-robin scheduler.
// slave = the scheduler, master = requesters plus the datapath side.
interface design_48_sched_if #(
  parameter int W = 16,
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           rsp_err;
  logic           busy;
  logic           dp_start;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_y;
  logic           dp_valid;

  modport slave (
    input  req, req_a, req_b, dp_y, dp_valid,
    output gnt, rsp_valid, rsp_y, rsp_err, busy, dp_start, dp_a, dp_b
  );

  modport master (
    output req, req_a, req_b, dp_y, dp_valid,
    input  gnt, rsp_valid, rsp_y, rsp_err, busy, dp_start, dp_a, dp_b
  );
endinterface

// File: rtl/design_48_sched.sv
// Round-robin scheduler sharing one design_48 datapath among N requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature macro: DESIGN_48_SCHED_TIMEOUT_EN adds a WAIT watchdog that
// answers with rsp_err=1, rsp_y=0 after TIMEOUT cycles without dp_valid.
module design_48_sched #(
  parameter int W       = 16,
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  design_48_sched_if.slave   bus
);
  localparam int PW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  // Parameter sanity check at elaboration time.
  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("design_48_sched: N must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  owner;
  logic [PW-1:0]  pick;
  logic           found;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           busy;
  logic           dp_start;
  // dp_a/dp_b double as the captured operand latch: loaded on grant and
  // held untouched until the next grant.
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;

`ifdef DESIGN_48_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]  to_cnt;
  logic           rsp_err;
  assign bus.rsp_err = rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.busy      = busy;
  assign bus.dp_start  = dp_start;
  assign bus.dp_a      = dp_a;
  assign bus.dp_b      = dp_b;

  // (p + k) mod N for small k without a divider.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[wrap_add(rr_ptr, k)]) begin
        pick  = wrap_add(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  // Scheduler FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
      dp_start  <= 1'b0;
      dp_a      <= '0;
      dp_b      <= '0;
`ifdef DESIGN_48_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= pick;
            dp_a     <= bus.req_a[pick*W +: W];
            dp_b     <= bus.req_b[pick*W +: W];
            gnt      <= ONE << pick;
            dp_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // dp_valid here is a zero-latency response and is ignored.
          gnt      <= '0;
          dp_start <= 1'b0;
`ifdef DESIGN_48_SCHED_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.dp_valid) begin
            rsp_y     <= bus.dp_y;
            rsp_valid <= ONE << owner;
`ifdef DESIGN_48_SCHED_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef DESIGN_48_SCHED_TIMEOUT_EN
          else if (to_cnt == CW'(TIMEOUT)) begin
            rsp_y     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE << owner;
            state     <= RESP;
          end else begin
            to_cnt    <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          rsp_valid <= '0;
`ifdef DESIGN_48_SCHED_TIMEOUT_EN
          rsp_err   <= 1'b0;
`endif
          rr_ptr    <= wrap_add(owner, 1);
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/design_48_sched.md
# design_48_sched

Round-robin scheduler that shares one design_48 datapath instance among N requesters. It accepts one operand pair at a time, issues it to the datapath with a start pulse and waits for the datapath valid. It then returns the result to the owning requester. It sits between the requester ports and the design_48 a/b/start/y/valid pins and is the only block that drives them.

## Interface
- W, 16, operand/result width (must match the design_48 instance)
- N, 4, number of requesters, 2..8
- TIMEOUT, 15, max cycles in WAIT before error response (used only with timeout feature)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N  per-requester request level
- req_a  in  N*W  operand a, requester i at [i*W +: W]
- req_b  in  N*W  operand b, requester i at [i*W +: W]
- gnt  out  N  one-hot, one-cycle pulse: request of i accepted, operands captured
- rsp_valid  out  N  one-hot, one-cycle pulse: result for requester i on rsp_y
- rsp_y  out  W  result, valid with rsp_valid
- rsp_err  out  1  qualifies rsp_valid: 1 = datapath timeout, rsp_y = 0
- busy  out  1  1 in any state other than IDLE
- dp_start  out  1  start pulse to datapath
- dp_a, dp_b  out  W  operands to datapath
- dp_y  in  W  datapath result
- dp_valid  in  1  datapath result valid

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE: if req != 0, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … N-1, 0 …). Latch owner, req_a/req_b slice into op_a/op_b, gnt[owner] <= 1, go ISSUE. If req == 0, stay.
- ISSUE: gnt high for exactly this cycle. dp_start = 1, dp_a/dp_b = op_a/op_b. Go WAIT.
- WAIT: dp_a/dp_b held. On dp_valid: rsp_y <= dp_y, rsp_err <= 0, rsp_valid[owner] <= 1, go RESP.
- RESP: rsp_valid high for exactly this cycle. rr_ptr <= (owner+1) mod N. Go IDLE.
- Requesters hold req and operands stable until gnt. They may drop req on or after gnt. req is sampled only in IDLE.
- dp_valid outside WAIT is ignored. dp_y is sampled only on the WAIT cycle with dp_valid = 1.
- dp_a/dp_b keep their last value outside ISSUE/WAIT. They reset to 0.
- Any single requester is served at most once per N grants while others are requesting. Starvation-free.

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_y=0, rsp_err=0, busy=0, dp_start=0, dp_a=dp_b=0, rr_ptr=0, state IDLE.
- req seen in IDLE at edge k: gnt and dp_start high in cycle k+1 (ISSUE).
- dp_valid high in cycle m (m ≥ k+2): rsp_valid high in cycle m+1.
- Next grant no earlier than cycle m+2, from the IDLE cycle that follows RESP.
- Zero-latency datapath response (dp_valid in the ISSUE cycle) is ignored. The datapath must assert dp_valid at least one cycle after dp_start, which design_48 satisfies.
- rst_n asserted mid-operation: the in-flight request is dropped without a response, and all state returns to reset values asynchronously. Requesters re-request after reset.

## Configuration
- DESIGN_48_SCHED_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without dp_valid, the block issues rsp_valid[owner] with rsp_err=1 and rsp_y=0, then goes to RESP.
  - If dp_valid and timeout occur in the same cycle, dp_valid wins.
- Not defined:
  - WAIT waits indefinitely for dp_valid.
  - rsp_err is tied 0.
  - No timeout counter is built.

## Test plan
- Single op: req=0001, a=0x0003, b=0x0004, datapath asserts dp_valid 1 cycle after dp_start. Required: gnt=0001 one cycle after req, rsp_valid=0001 with rsp_y = design_48 result, rsp_err=0, busy low again after RESP.
- Contention: req=1111 held continuously. Required: grant order 0,1,2,3,0; each gnt one-hot; no rsp_valid without a preceding gnt to the same index.
- Round-robin skip: rr_ptr=2 (after serving 1), req=0011. Required: grant to 0, then to 1.
- Spurious valid: dp_valid pulsed while IDLE and during ISSUE. Required: no rsp_valid; the result is captured only from the later dp_valid in WAIT.
- Timeout (macro on, TIMEOUT=15): dp_valid never asserted. Required: rsp_valid[owner]=1, rsp_err=1, rsp_y=0 exactly 16 cycles after entering WAIT. With the macro off, busy stays 1 indefinitely.
- Reset mid-WAIT: drop rst_n for 2 cycles. Required: all outputs return to 0 immediately, no rsp_valid follows, and the next req=1000 is granted to requester 3.
